// File: rtl/approx_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : approx_seq_mul
// Description : Iterative shift-add unsigned multiplier. One partial-product
//               row per cycle, accumulated through a ripple adder whose low
//               columns can switch to the approx_fa_5_250 cell per operation.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_seq_mul #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   IN1,
    input  logic [WIDTH-1:0]   IN2,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] Out
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_sum;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: partial-product row and column-wise ripple adder
    // ------------------------------------------------------------------------
    assign w_pp = {{WIDTH{1'b0}}, (a_q & {WIDTH{b_q[cnt_q]}})} << cnt_q;

    // Approximate cell ignores the PP bit entirely: S = ~(X&Z), Cout = X&Z.
    always_comb begin : p_adder
        logic carry;
        carry = 1'b0;
        w_sum = '0;
        for (int c = 0; c < PW; c++) begin
            if (mode_q && (c < APPROX_COLS)) begin
                w_sum[c] = ~(acc_q[c] & carry);
                carry    = acc_q[c] & carry;
            end else begin
                w_sum[c] = acc_q[c] ^ w_pp[c] ^ carry;
                carry    = (acc_q[c] & w_pp[c]) | (acc_q[c] & carry) | (w_pp[c] & carry);
            end
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = IN1;
                    b_d    = IN2;
                    mode_d = approx_en;
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end
            S_RUN: begin
                acc_d = w_sum;
                if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
        Out       = acc_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_approx_seq_mul.sv
`default_nettype none
// Randomised scoreboard bench for approx_seq_mul (WIDTH=8, APPROX_COLS=4).
module tb_approx_seq_mul;

    localparam int W  = 8;
    localparam int AC = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    IN1 = '0;
    logic [W-1:0]    IN2 = '0;
    logic            approx_en = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  Out;

    approx_seq_mul #(.WIDTH(W), .APPROX_COLS(AC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .IN1       (IN1),
        .IN2       (IN2),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] exp;
        int             acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rdy_mode = 2;   // 0 random, 1 held low, 2 held high

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Golden model: exact product, or row-by-row bit-serial ripple with approximate low columns.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        logic [2*W-1:0] acc;
        logic [2*W-1:0] pp;
        logic           cy, x, y;
        if (!m) return (2*W)'(a) * (2*W)'(b);
        acc = '0;
        for (int r = 0; r < W; r++) begin
            pp = b[r] ? ((2*W)'(a) << r) : '0;
            cy = 1'b0;
            for (int c = 0; c < 2*W; c++) begin
                x = acc[c];
                y = pp[c];
                if (c < AC) begin
                    acc[c] = ~(x & cy);
                    cy     = x & cy;
                end else begin
                    acc[c] = x ^ y ^ cy;
                    cy     = (x & y) | (x & cy) | (y & cy);
                end
            end
        end
        return acc;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [2*W-1:0] exp);
        int budget;
        budget = 0;
        @(negedge clk);
        IN1 = a; IN2 = b; approx_en = m; in_valid = 1'b1;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            sb.push_back('{exp, cyc});
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            IN1       = W'($urandom);
            IN2       = W'($urandom);
            approx_en = 1'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    logic           prev_valid = 1'b0;
    logic           held = 1'b0;
    logic [2*W-1:0] held_val = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_valid = 1'b0;
                held       = 1'b0;
                continue;
            end
            if (out_valid) chk("in_ready_in_done", 32'(in_ready), 32'd0);
            if (held && out_valid) chk("out_stable", 32'(Out), 32'(held_val));
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
                else chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(W + 1));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("product", 32'(Out), 32'(e.exp));
            end
            held       = out_valid && !out_ready;
            held_val   = Out;
            prev_valid = out_valid;
        end
    end

    initial begin
        logic [W-1:0] a, b;
        logic         m;
        int           n, accepts;

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out", 32'(Out), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed corner cases
        rdy_mode = 2;
        issue(8'd255, 8'd255, 1'b0, 16'hFE01);
        issue(8'd0,   8'd0,   1'b1, 16'h000F);
        issue(8'd0,   8'd0,   1'b0, 16'h0000);
        issue(8'd1,   8'd1,   1'b0, 16'h0001);
        wait_idle();

        // Continuous in_valid: one acceptance per IDLE visit, II = W+2
        IN1 = 8'd37; IN2 = 8'd91; approx_en = 1'b1; in_valid = 1'b1;
        accepts = 0;
        for (int k = 0; k < 4 * (W + 2); k++) begin
            if (in_ready) begin
                sb.push_back('{model(8'd37, 8'd91, 1'b1), cyc});
                accepts++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("ii_accept_count", 32'(accepts), 32'd4);
        wait_idle();

        // Backpressure with a pending request
        rdy_mode = 1;
        @(negedge clk);
        issue(8'd200, 8'd77, 1'b0, 16'd15400);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_rise", 32'(out_valid), 32'd1);
        IN1 = 8'd13; IN2 = 8'd11; approx_en = 1'b0; in_valid = 1'b1;
        repeat (20) @(negedge clk);
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_next_ready", 32'(in_ready), 32'd1);
        sb.push_back('{16'd143, cyc});
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();

        // Reset in cycle 3 of RUN
        issue(8'd99, 8'd45, 1'b1, model(8'd99, 8'd45, 1'b1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_idle_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(Out), 32'd0);
        repeat (W + 4) @(negedge clk);
        issue(8'd13, 8'd11, 1'b0, 16'd143);
        wait_idle();

        // Randomised traffic with random backpressure
        rdy_mode = 0;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0:       a = 8'd0;
                1:       a = 8'd255;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = 8'd0;
                1:       b = 8'd255;
                default: b = W'($urandom);
            endcase
            m = 1'($urandom);
            issue(a, b, m, model(a, b, m));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        rdy_mode = 2;
        wait_idle();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
